ice_reg_responder: RTL and testbench

- Generic register-file endpoint on the ICE internal bus.
- Decodes master-bus frames addressed to it and executes 32-bit register reads and writes.
- Arbitrates for the shared slave output bus and returns an ACK or NAK response frame carrying the originating event id.
- Is the responder end of the master/slave bus that ice_bus_controller drives; instantiated alongside basics_int, gpio_int and pmu_int.

---
 rtl/ice_reg_responder.sv | 245 ++++++++++++++++++++++++
 tb/tb_ice_reg_responder.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ice_reg_responder.sv
// ice_reg_responder: register-file endpoint on the ICE internal bus.
// Receives master frames {event id, reg index, up to 4 write bytes} addressed to MY_ADDR,
// runs one register read or write, and returns an ACK/NAK frame on the slave bus.
// The ICE_RESP_WRITE_ECHO_EN macro adds the new register value to the write ACK payload.
module ice_reg_responder #(
    parameter logic [7:0]  MY_ADDR   = 8'h72,
    parameter int unsigned NUM_REGS  = 4,
    parameter logic [31:0] RESET_VAL = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [7:0]               ma_data,
    input  logic [7:0]               ma_addr,
    input  logic                     ma_data_valid,
    input  logic                     ma_frame_valid,
    input  logic                     sl_overflow,
    output logic                     sl_arb_request,
    input  logic                     sl_arb_grant,
    output logic [8:0]               sl_addr,
    output logic [8:0]               sl_data,
    output logic [8:0]               sl_tail,
    output logic                     sl_latch_tail,
    output logic [32*NUM_REGS-1:0]   reg_out,
    output logic [NUM_REGS-1:0]      reg_wr_strobe,
    output logic                     busy,
    output logic [7:0]               drop_count
);

    typedef enum logic [2:0] {StIdle, StRx, StDecode, StArb, StTx, StTail} state_e;

`ifdef ICE_RESP_WRITE_ECHO_EN
    localparam logic [2:0] WrAckLen = 3'd5;
`else
    localparam logic [2:0] WrAckLen = 3'd1;
`endif

    state_e                       state_q, state_d;
    logic                         fv_q;
    logic [5:0][7:0]              buf_q, buf_d;
    logic [2:0]                   cnt_q, cnt_d;
    logic                         ovf_q, ovf_d;
    logic [NUM_REGS-1:0][31:0]    regs_q, regs_d;
    logic [NUM_REGS-1:0]          strobe_q, strobe_d;
    logic [7:0]                   drop_q, drop_d;
    logic                         nak_q, nak_d;
    logic [2:0]                   len_q, len_d;
    logic [2:0]                   idx_q, idx_d;
    logic [31:0]                  word_q, word_d;

    logic                         frame_start;
    logic                         idx_hit;
    logic [31:0]                  rd_word;
    logic [31:0]                  wr_word;
    logic [7:0]                   tx_byte;

    assign frame_start   = ma_frame_valid && !fv_q && (ma_addr == MY_ADDR);
    assign reg_out       = regs_q;
    assign reg_wr_strobe = strobe_q;
    assign drop_count    = drop_q;
    assign busy          = (state_q != StIdle);

    // State and datapath registers, all cleared asynchronously.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            fv_q     <= 1'b0;
            buf_q    <= '0;
            cnt_q    <= 3'd0;
            ovf_q    <= 1'b0;
            regs_q   <= {NUM_REGS{RESET_VAL}};
            strobe_q <= '0;
            drop_q   <= 8'd0;
            nak_q    <= 1'b0;
            len_q    <= 3'd0;
            idx_q    <= 3'd0;
            word_q   <= 32'd0;
        end else begin
            state_q  <= state_d;
            fv_q     <= ma_frame_valid;
            buf_q    <= buf_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            regs_q   <= regs_d;
            strobe_q <= strobe_d;
            drop_q   <= drop_d;
            nak_q    <= nak_d;
            len_q    <= len_d;
            idx_q    <= idx_d;
            word_q   <= word_d;
        end
    end

    // Register-index lookup and right-aligned write word from the captured bytes.
    always_comb begin
        idx_hit = 1'b0;
        rd_word = 32'd0;
        for (int i = 0; i < int'(NUM_REGS); i++) begin
            if (buf_q[1] == 8'(i)) begin
                idx_hit = 1'b1;
                rd_word = regs_q[i];
            end
        end
        unique case (cnt_q)
            3'd3:    wr_word = {24'd0, buf_q[2]};
            3'd4:    wr_word = {16'd0, buf_q[2], buf_q[3]};
            3'd5:    wr_word = {8'd0, buf_q[2], buf_q[3], buf_q[4]};
            3'd6:    wr_word = {buf_q[2], buf_q[3], buf_q[4], buf_q[5]};
            default: wr_word = 32'd0;
        endcase
    end

    // Next-state: frame capture, command decode, arbitration and payload sequencing.
    always_comb begin
        state_d  = state_q;
        buf_d    = buf_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        regs_d   = regs_q;
        strobe_d = '0;
        drop_d   = drop_q;
        nak_d    = nak_q;
        len_d    = len_q;
        idx_d    = idx_q;
        word_d   = word_q;

        if (frame_start && (state_q != StIdle) && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end

        unique case (state_q)
            StIdle: begin
                if (frame_start) begin
                    state_d = StRx;
                    buf_d   = '0;
                    ovf_d   = 1'b0;
                    cnt_d   = 3'd0;
                    if (ma_data_valid) begin
                        buf_d[0] = ma_data;
                        cnt_d    = 3'd1;
                    end
                end
            end
            StRx: begin
                // A byte arriving with the frame_valid fall is still taken.
                if (ma_data_valid) begin
                    if (cnt_q < 3'd6) begin
                        buf_d[cnt_q] = ma_data;
                        cnt_d        = cnt_q + 3'd1;
                    end else begin
                        ovf_d = 1'b1;
                    end
                end
                if (!ma_frame_valid) begin
                    state_d = StDecode;
                end
            end
            StDecode: begin
                idx_d = 3'd0;
                if (cnt_q == 3'd0) begin
                    state_d = StIdle;
                end else if ((cnt_q == 3'd1) || ovf_q || !idx_hit) begin
                    state_d = StArb;
                    nak_d   = 1'b1;
                    len_d   = 3'd1;
                    word_d  = 32'd0;
                end else if (cnt_q == 3'd2) begin
                    state_d = StArb;
                    nak_d   = 1'b0;
                    len_d   = 3'd5;
                    word_d  = rd_word;
                end else begin
                    state_d = StArb;
                    nak_d   = 1'b0;
                    len_d   = WrAckLen;
                    word_d  = wr_word;
                    for (int i = 0; i < int'(NUM_REGS); i++) begin
                        if (buf_q[1] == 8'(i)) begin
                            regs_d[i]   = wr_word;
                            strobe_d[i] = 1'b1;
                        end
                    end
                end
            end
            StArb: begin
                if (sl_arb_grant) begin
                    state_d = StTx;
                end
            end
            StTx: begin
                // Backpressure holds the byte index; nothing is emitted meanwhile.
                if (!sl_overflow) begin
                    if (idx_q == len_q - 3'd1) begin
                        state_d = StTail;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            StTail: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Slave-bus outputs decoded from state; zero whenever the bus is not owned.
    always_comb begin
        sl_arb_request = 1'b0;
        sl_addr        = 9'd0;
        sl_data        = 9'd0;
        sl_tail        = 9'd0;
        sl_latch_tail  = 1'b0;

        unique case (idx_q)
            3'd0:    tx_byte = buf_q[0];
            3'd1:    tx_byte = word_q[31:24];
            3'd2:    tx_byte = word_q[23:16];
            3'd3:    tx_byte = word_q[15:8];
            3'd4:    tx_byte = word_q[7:0];
            default: tx_byte = 8'd0;
        endcase

        unique case (state_q)
            StArb: begin
                sl_arb_request = 1'b1;
            end
            StTx: begin
                sl_addr = {1'b1, 7'd0, nak_q};
                if (!sl_overflow) begin
                    sl_data = {1'b1, tx_byte};
                end
            end
            StTail: begin
                sl_addr       = {1'b1, 7'd0, nak_q};
                sl_tail       = {1'b1, 5'd0, len_q};
                sl_latch_tail = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_ice_reg_responder.sv
// Directed, table-driven bench for ice_reg_responder (NUM_REGS=4, RESET_VAL=0).
module tb_ice_reg_responder;

`ifdef ICE_RESP_WRITE_ECHO_EN
    localparam int WLEN = 5;
`else
    localparam int WLEN = 1;
`endif

    logic         clk;
    logic         reset_n;
    logic [7:0]   ma_data;
    logic [7:0]   ma_addr;
    logic         ma_data_valid;
    logic         ma_frame_valid;
    logic         sl_overflow;
    logic         sl_arb_request;
    logic         sl_arb_grant;
    logic [8:0]   sl_addr;
    logic [8:0]   sl_data;
    logic [8:0]   sl_tail;
    logic         sl_latch_tail;
    logic [127:0] reg_out;
    logic [3:0]   reg_wr_strobe;
    logic         busy;
    logic [7:0]   drop_count;

    int checks = 0;
    int failures = 0;

    ice_reg_responder #(
        .MY_ADDR   (8'h72),
        .NUM_REGS  (4),
        .RESET_VAL (32'h0000_0000)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .ma_data        (ma_data),
        .ma_addr        (ma_addr),
        .ma_data_valid  (ma_data_valid),
        .ma_frame_valid (ma_frame_valid),
        .sl_overflow    (sl_overflow),
        .sl_arb_request (sl_arb_request),
        .sl_arb_grant   (sl_arb_grant),
        .sl_addr        (sl_addr),
        .sl_data        (sl_data),
        .sl_tail        (sl_tail),
        .sl_latch_tail  (sl_latch_tail),
        .reg_out        (reg_out),
        .reg_wr_strobe  (reg_wr_strobe),
        .busy           (busy),
        .drop_count     (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]   addr;
        int           n;
        logic [55:0]  b;
        logic         exp_req;
        logic         exp_nak;
        int           exp_len;
        logic [39:0]  p;
        logic [3:0]   exp_strobe;
        logic [127:0] exp_regs;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] addr, input int n, input logic [55:0] b);
        @(negedge clk);
        ma_addr        = addr;
        ma_frame_valid = 1'b1;
        ma_data_valid  = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (i > 0) @(negedge clk);
            ma_data       = b[55-8*i -: 8];
            ma_data_valid = 1'b1;
        end
        @(negedge clk);
        ma_frame_valid = 1'b0;
        ma_data_valid  = 1'b0;
        ma_data        = 8'd0;
    endtask

    // Called right after the frame_valid fall; request must rise exactly two cycles later.
    task automatic check_latency(input string name, input logic [3:0] exp_strobe);
        @(negedge clk);
        check({name, "_req_early"}, 128'(sl_arb_request), 128'(0));
        @(negedge clk);
        check({name, "_req"}, 128'(sl_arb_request), 128'(1));
        check({name, "_strobe"}, 128'(reg_wr_strobe), 128'(exp_strobe));
    endtask

    task automatic run_rsp(input string name, input logic nak, input int len,
                           input logic [39:0] p, input int ovf_at);
        int  k = 0;
        int  ovf_left = 0;
        bit  ovf_used = 0;
        bit  done = 0;
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            @(negedge clk);
            if (cyc == 0) check({name, "_strobe_clr"}, 128'(reg_wr_strobe), 128'(0));
            if (sl_overflow) check({name, "_stall"}, 128'(sl_data[8]), 128'(0));
            if (sl_data[8]) begin
                if (k < len) begin
                    check({name, "_byte"}, 128'(sl_data[7:0]), 128'(p[39-8*k -: 8]));
                end else begin
                    check({name, "_extra_byte"}, 128'(k), 128'(len - 1));
                end
                if (k == 0) check({name, "_type"}, 128'(sl_addr), 128'({2'b10, 6'd0, nak}));
                k++;
            end
            if (sl_latch_tail) begin
                check({name, "_tail"}, 128'(sl_tail), 128'(9'h100 | 9'(len)));
                check({name, "_count"}, 128'(k), 128'(len));
                done = 1;
            end
            if (ovf_left > 0) begin
                ovf_left--;
                if (ovf_left == 0) sl_overflow = 1'b0;
            end else if (!ovf_used && ovf_at > 0 && k == ovf_at) begin
                sl_overflow = 1'b1;
                ovf_left    = 3;
                ovf_used    = 1;
            end
        end
        if (!done) begin
            check({name, "_tail_timeout"}, 128'(0), 128'(1));
        end else begin
            @(negedge clk);
            check({name, "_idle_after"},
                  128'({sl_arb_request, busy, sl_addr, sl_data, sl_tail, sl_latch_tail}), 128'(0));
        end
    endtask

    localparam logic [127:0] R1 = {32'h0, 32'hDEADBEEF, 32'h0, 32'h0};
    localparam logic [127:0] R5 = {32'h0, 32'hDEADBEEF, 32'h0000_00A5, 32'h0};
    localparam logic [127:0] R8 = {32'h0, 32'hDEADBEEF, 32'h0000_00A5, 32'h0000_1234};

    initial begin
        bit seen_req;
        bit seen_busy;
        bit seen_byte;

        vecs[0]  = '{8'h72, 6, 56'h11_02_DE_AD_BE_EF_00, 1'b1, 1'b0, WLEN, 40'h11_DE_AD_BE_EF, 4'b0100, R1};
        vecs[1]  = '{8'h72, 2, 56'h22_02_00_00_00_00_00, 1'b1, 1'b0, 5,    40'h22_DE_AD_BE_EF, 4'b0000, R1};
        vecs[2]  = '{8'h72, 2, 56'h33_04_00_00_00_00_00, 1'b1, 1'b1, 1,    40'h33_00_00_00_00, 4'b0000, R1};
        vecs[3]  = '{8'h72, 7, 56'h44_01_01_02_03_04_05, 1'b1, 1'b1, 1,    40'h44_00_00_00_00, 4'b0000, R1};
        vecs[4]  = '{8'h72, 3, 56'h55_01_A5_00_00_00_00, 1'b1, 1'b0, WLEN, 40'h55_00_00_00_A5, 4'b0010, R5};
        vecs[5]  = '{8'h72, 2, 56'h66_01_00_00_00_00_00, 1'b1, 1'b0, 5,    40'h66_00_00_00_A5, 4'b0000, R5};
        vecs[6]  = '{8'h72, 1, 56'h77_00_00_00_00_00_00, 1'b1, 1'b1, 1,    40'h77_00_00_00_00, 4'b0000, R5};
        vecs[7]  = '{8'h72, 4, 56'h88_00_12_34_00_00_00, 1'b1, 1'b0, WLEN, 40'h88_00_00_12_34, 4'b0001, R8};
        vecs[8]  = '{8'h72, 2, 56'h99_03_00_00_00_00_00, 1'b1, 1'b0, 5,    40'h99_00_00_00_00, 4'b0000, R8};
        vecs[9]  = '{8'h55, 3, 56'h10_00_FF_00_00_00_00, 1'b0, 1'b0, 0,    40'h0,              4'b0000, R8};
        vecs[10] = '{8'h72, 0, 56'h0,                    1'b0, 1'b0, 0,    40'h0,              4'b0000, R8};

        reset_n        = 1'b0;
        ma_data        = 8'd0;
        ma_addr        = 8'd0;
        ma_data_valid  = 1'b0;
        ma_frame_valid = 1'b0;
        sl_overflow    = 1'b0;
        sl_arb_grant   = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_outputs", 128'({sl_arb_request, sl_addr, sl_data, sl_tail, sl_latch_tail,
                                     reg_wr_strobe, busy, drop_count}), 128'(0));
        check("reset_regs", reg_out, 128'(0));
        reset_n = 1'b1;

        for (int v = 0; v < 11; v++) begin
            send_frame(vecs[v].addr, vecs[v].n, vecs[v].b);
            if (vecs[v].exp_req) begin
                check_latency($sformatf("v%0d", v), vecs[v].exp_strobe);
                run_rsp($sformatf("v%0d", v), vecs[v].exp_nak, vecs[v].exp_len, vecs[v].p, 0);
            end else begin
                seen_req  = 0;
                seen_busy = 0;
                repeat (8) begin
                    @(negedge clk);
                    seen_req  |= sl_arb_request;
                    seen_busy |= busy;
                end
                check($sformatf("v%0d_no_req", v), 128'(seen_req), 128'(0));
                if (vecs[v].addr != 8'h72) check($sformatf("v%0d_no_busy", v), 128'(seen_busy), 128'(0));
            end
            check($sformatf("v%0d_regs", v), reg_out, vecs[v].exp_regs);
        end

        // Backpressure for three cycles after the second payload byte of a read.
        send_frame(8'h72, 2, 56'hAB_02_00_00_00_00_00);
        check_latency("ovf", 4'b0000);
        run_rsp("ovf", 1'b0, 5, 40'hAB_DE_AD_BE_EF, 2);

        // Matching frames arriving while parked in ARB are dropped and counted.
        sl_arb_grant = 1'b0;
        send_frame(8'h72, 2, 56'hC1_02_00_00_00_00_00);
        check_latency("drop", 4'b0000);
        send_frame(8'h72, 1, 56'h5A_00_00_00_00_00_00);
        check("drop_one", 128'(drop_count), 128'(1));
        for (int i = 0; i < 299; i++) send_frame(8'h72, 1, 56'h5A_00_00_00_00_00_00);
        check("drop_sat", 128'(drop_count), 128'(255));
        check("drop_no_grant_bus", 128'({sl_addr, sl_data}), 128'(0));
        check("drop_still_req", 128'(sl_arb_request), 128'(1));
        sl_arb_grant = 1'b1;
        run_rsp("drop_rd", 1'b0, 5, 40'hC1_DE_AD_BE_EF, 0);
        check("drop_regs", reg_out, R8);

        // Asynchronous reset in the middle of a transmission.
        send_frame(8'h72, 2, 56'hD1_02_00_00_00_00_00);
        seen_byte = 0;
        for (int i = 0; i < 10 && !seen_byte; i++) begin
            @(negedge clk);
            seen_byte = sl_data[8];
        end
        check("rst_tx_reached", 128'(seen_byte), 128'(1));
        #2 reset_n = 1'b0;
        #1;
        check("rst_outputs", 128'({sl_arb_request, sl_addr, sl_data, sl_tail, sl_latch_tail,
                                   reg_wr_strobe, busy, drop_count}), 128'(0));
        check("rst_regs", reg_out, 128'(0));
        @(negedge clk);
        reset_n = 1'b1;

        send_frame(8'h72, 2, 56'hE1_02_00_00_00_00_00);
        check_latency("post_rst", 4'b0000);
        run_rsp("post_rst", 1'b0, 5, 40'hE1_00_00_00_00, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
